// File: rtl/step_alu_pkg.sv
// Shared encodings for step_alu_reg: operation select and run-control states.
package step_alu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_XOR   = 2'b10,
    OP_SHIFT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/step_alu_reg_tick_gen.sv
// Free-running prescaler: tick is high for one clk every 2^PRESCALE_BITS clocks.
module tick_gen #(
  parameter int PRESCALE_BITS = 26
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [PRESCALE_BITS-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + PRESCALE_BITS'(1);
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/step_alu_reg.sv
// Stepped ALU register: applies a latched op to q once per prescaler tick for a programmed step count.
// Define STEP_ALU_ROTATE_EN to make SHIFT rotate (with carry collecting the rotated-out bit).
module step_alu_reg
  import step_alu_pkg::*;
#(
  parameter int WIDTH         = 5,
  parameter int PRESCALE_BITS = 26,
  parameter int STEP_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 shift_dir,
  input  logic [STEP_BITS-1:0] steps,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic                 carry
);

  // Returns {carry_out, shifted_value} for a one-bit shift toward dir (1 = right).
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                input logic dir,
                                                input logic c);
`ifdef STEP_ALU_ROTATE_EN
    if (dir) shift_step = {c | v[0], v[0], v[WIDTH-1:1]};
    else     shift_step = {c | v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
`else
    if (dir) shift_step = {c, 1'b0, v[WIDTH-1:1]};
    else     shift_step = {c, v[WIDTH-2:0], 1'b0};
`endif
  endfunction

  logic                 tick;
  state_e               state_q;
  op_e                  op_q;
  logic                 dir_q;
  logic [STEP_BITS-1:0] rem_q;
  logic [WIDTH-1:0]     operand_q;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 carry_q, carry_d;
  logic                 busy_q, done_q;
  logic [WIDTH:0]       sum;

  tick_gen #(.PRESCALE_BITS(PRESCALE_BITS)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    sum     = {1'b0, q_q} + {1'b0, operand_q};
    case (op_q)
      OP_LOAD: q_d = operand_q;
      OP_ADD: begin
        q_d     = sum[WIDTH-1:0];
        carry_d = carry_q | sum[WIDTH];
      end
      OP_XOR:  q_d = q_q ^ operand_q;
      default: {carry_d, q_d} = shift_step(q_q, dir_q, carry_q);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      operand_q <= '0;
      q_q       <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A tick coinciding with start is deliberately dropped: only RUN consumes ticks.
          if (start) begin
            operand_q <= din;
            op_q      <= op_e'(op);
            dir_q     <= shift_dir;
            rem_q     <= steps;
            carry_q   <= 1'b0;
            if (steps == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (tick) begin
            q_q     <= q_d;
            carry_q <= carry_d;
            rem_q   <= rem_q - STEP_BITS'(1);
            if (rem_q == STEP_BITS'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign carry = carry_q;

endmodule
